if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 16-bit, 8-register pipelined CPU. It owns the program counter and issues word-addressed fetches to instruction memory over a req/ack handshake. It buffers a returned instruction while the hazard detection unit stalls the front end, and flushes on branch/jump redirects from EX. It feeds the decode stage, whose instruction word the hazard detection unit inspects.

---
 rtl/if_stage_if.sv | 10 +
 rtl/if_stage.sv | 131 +++++++++++++
 tb/tb_if_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch port: word-addressed request with a same-cycle ack and read data.
interface if_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage and IF/ID register: owns the PC, fetches over a req/ack port,
// buffers a word across hazard stalls and squashes in-flight fetches on EX redirects.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        if_id_en,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    if_stage_if.master  imem,
    output logic [15:0] if_id_inst,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] hold_buf_q, hold_buf_d;
    logic [15:0] redir_pc_q, redir_pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;

    logic        advance;
    logic        deliver;
    logic [15:0] deliver_word;

    assign advance = pc_en & if_id_en;

    // Request and address come straight from flops so ack/redirect never reach them.
    assign imem.imem_req  = (state_q == S_FETCH) || (state_q == S_DROP);
    assign imem.imem_addr = pc_q;

    assign if_id_inst  = inst_q;
    assign if_id_pc    = ifpc_q;
    assign if_id_valid = valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_buf_d   = hold_buf_q;
        redir_pc_d   = redir_pc_q;
        deliver      = 1'b0;
        deliver_word = NOP_INST;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem.imem_ack) begin
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else if (advance) begin
                        deliver      = 1'b1;
                        deliver_word = imem.imem_rdata;
                        pc_d         = pc_q + 16'd1;
                    end else begin
                        hold_buf_d = imem.imem_rdata;
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Request cannot be withdrawn; wait out its ack, then jump.
                    redir_pc_d = redirect_pc;
                    state_d    = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end else if (advance) begin
                    deliver      = 1'b1;
                    deliver_word = hold_buf_q;
                    pc_d         = pc_q + 16'd1;
                    state_d      = S_FETCH;
                end
            end
            S_DROP: begin
                if (imem.imem_ack) begin
                    pc_d    = redirect_valid ? redirect_pc : redir_pc_q;
                    state_d = S_FETCH;
                end else if (redirect_valid) begin
                    redir_pc_d = redirect_pc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        inst_d  = inst_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        if (redirect_valid) begin
            inst_d  = NOP_INST;
            ifpc_d  = pc_q;
            valid_d = 1'b0;
        end else if (deliver) begin
            inst_d  = deliver_word;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
        end else if (if_id_en) begin
            inst_d  = NOP_INST;
            ifpc_d  = pc_q;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            hold_buf_q <= 16'h0000;
            redir_pc_q <= 16'h0000;
            inst_q     <= NOP_INST;
            ifpc_q     <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_buf_q <= hold_buf_d;
            redir_pc_q <= redir_pc_d;
            inst_q     <= inst_d;
            ifpc_q     <= ifpc_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed hazard/redirect/reset scenarios plus a
// randomized run, all compared every cycle against a transaction-level fetch model.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        pc_en = 1'b0, if_id_en = 1'b0, redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] if_id_inst, if_id_pc;
    logic        if_id_valid;
    logic [15:0] inst2, pc2;
    logic        valid2;

    if_stage_if imem ();
    if_stage_if imem2 ();

    if_stage u_dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .if_id_en(if_id_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem(imem),
        .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
    );

    if_stage #(.RESET_PC(16'hFFFE)) u_dut2 (
        .clk(clk), .rst(rst), .pc_en(1'b1), .if_id_en(1'b1),
        .redirect_valid(1'b0), .redirect_pc(16'h0000), .imem(imem2),
        .if_id_inst(inst2), .if_id_pc(pc2), .if_id_valid(valid2)
    );
    assign imem2.imem_ack   = imem2.imem_req;
    assign imem2.imem_rdata = imem2.imem_addr ^ 16'hA5A5;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int lat_fixed = 0;   // <0 selects a random latency per request
    int wcnt = 0, cur_lat = 0;
    initial begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 16'h0000;
    end

    task automatic step(input bit pe, input bit ie, input bit rv, input logic [15:0] rpc);
        @(posedge clk);
        #1;
        pc_en = pe; if_id_en = ie; redirect_valid = rv; redirect_pc = rpc;
        if (imem.imem_req) begin
            if (wcnt == 0) cur_lat = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
            if (wcnt >= cur_lat) begin
                imem.imem_ack   = 1'b1;
                imem.imem_rdata = imem.imem_addr ^ 16'hA5A5;
                wcnt = 0;
            end else begin
                imem.imem_ack   = 1'b0;
                imem.imem_rdata = 16'($urandom);
                wcnt++;
            end
        end else begin
            imem.imem_ack   = 1'b0;
            imem.imem_rdata = 16'($urandom);
            wcnt = 0;
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    bit          m_active, m_buf_valid, m_discard, m_new;
    logic [15:0] m_pc, m_buf, m_discard_pc;
    logic [15:0] exp_inst, exp_pc;
    bit          exp_valid;
    logic [15:0] log_pc[$], log_inst[$];

    always @(negedge clk) begin : compare
        bit          adv, dlv;
        logic [15:0] w, p;
        if (rst) begin
            m_active = 0; m_buf_valid = 0; m_discard = 0; m_new = 0;
            m_pc = 16'h0000; exp_inst = 16'h0000; exp_pc = 16'h0000; exp_valid = 0;
            chk("rst_req", imem.imem_req, 0);
            chk("rst_addr", imem.imem_addr, 16'h0000);
            chk("rst_inst", if_id_inst, 16'h0000);
            chk("rst_ifpc", if_id_pc, 16'h0000);
            chk("rst_valid", if_id_valid, 0);
        end else begin
            chk("req", imem.imem_req, m_active && !m_buf_valid);
            if (imem.imem_req) chk("addr", imem.imem_addr, m_pc);
            chk("inst", if_id_inst, exp_inst);
            chk("ifpc", if_id_pc, exp_pc);
            chk("valid", if_id_valid, exp_valid);
            if (m_new) begin log_pc.push_back(if_id_pc); log_inst.push_back(if_id_inst); end

            adv = pc_en && if_id_en; dlv = 0; w = 16'h0000; p = m_pc;
            if (!m_active) begin
                m_active = 1;
            end else if (m_discard) begin
                if (imem.imem_ack) begin
                    m_pc = redirect_valid ? redirect_pc : m_discard_pc;
                    m_discard = 0;
                end else if (redirect_valid) m_discard_pc = redirect_pc;
            end else if (m_buf_valid) begin
                if (redirect_valid) begin
                    m_buf_valid = 0; m_pc = redirect_pc;
                end else if (adv) begin
                    dlv = 1; w = m_buf; m_buf_valid = 0; m_pc = m_pc + 16'd1;
                end
            end else if (imem.imem_ack) begin
                if (redirect_valid) m_pc = redirect_pc;
                else if (adv) begin dlv = 1; w = imem.imem_rdata; m_pc = m_pc + 16'd1; end
                else begin m_buf = imem.imem_rdata; m_buf_valid = 1; end
            end else if (redirect_valid) begin
                m_discard = 1; m_discard_pc = redirect_pc;
            end

            if (redirect_valid) begin exp_inst = 16'h0000; exp_pc = p; exp_valid = 0; end
            else if (dlv)       begin exp_inst = w;        exp_pc = p; exp_valid = 1; end
            else if (if_id_en)  begin exp_inst = 16'h0000; exp_pc = p; exp_valid = 0; end
            m_new = dlv && !redirect_valid;
        end
    end

    logic [15:0] log2[$];
    always @(negedge clk)
        if (!rst && valid2 && log2.size() < 3) log2.push_back(pc2);

    // ---------------- directed + random stimulus ----------------
    initial begin
        repeat (3) step(0, 0, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        rst = 1'b0;                                  // IDLE cycle
        repeat (5) step(1, 1, 0, 16'h0);             // deliver 0..4
        step(0, 0, 0, 16'h0);                        // addr 5 acked, stalled
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 16'h0);
            chk("hold_req", imem.imem_req, 0);
            chk("hold_ifpc", if_id_pc, 16'h0004);
        end
        repeat (3) step(1, 1, 0, 16'h0);             // deliver 5, 6, 7
        lat_fixed = 3;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 16'h0);
            chk("wait_addr", imem.imem_addr, 16'h0008);
            if (i > 0) chk("wait_bubble", if_id_valid, 0);
        end
        lat_fixed = 2;
        step(1, 1, 1, 16'h0040);
        chk("drop_addr0", imem.imem_addr, 16'h0009);
        step(1, 1, 0, 16'h0);
        chk("redir_bubble", if_id_valid, 0);
        chk("drop_addr1", imem.imem_addr, 16'h0009);
        chk("drop_req", imem.imem_req, 1);
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        chk("redir_addr", imem.imem_addr, 16'h0040);
        chk("log_size", log_pc.size(), 9);
        for (int i = 0; i < 9 && i < log_pc.size(); i++) begin
            chk("seq_pc", log_pc[i], i);
            chk("seq_inst", log_inst[i], 16'(i) ^ 16'hA5A5);
        end

        lat_fixed = -1;
        repeat (3000)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, 16'($urandom));

        step(0, 0, 0, 16'h0);
        rst = 1'b1; wcnt = 0;
        step(0, 0, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        rst = 1'b0;
        lat_fixed = 0;
        for (int i = 0; i < 20 && !(imem.imem_req && imem.imem_addr == 16'h0002); i++)
            step(1, 1, 0, 16'h0);
        chk("reach_addr2", imem.imem_addr, 16'h0002);
        lat_fixed = 5;
        step(1, 1, 0, 16'h0);
        chk("pend_addr", imem.imem_addr, 16'h0003);
        chk("pend_req", imem.imem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_req", imem.imem_req, 0);
        chk("async_addr", imem.imem_addr, 16'h0000);
        chk("async_inst", if_id_inst, 16'h0000);
        chk("async_ifpc", if_id_pc, 16'h0000);
        chk("async_valid", if_id_valid, 0);
        wcnt = 0;
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        rst = 1'b0;
        chk("idle_req", imem.imem_req, 0);
        step(1, 1, 0, 16'h0);
        chk("first_req", imem.imem_req, 1);
        chk("first_addr", imem.imem_addr, 16'h0000);
        repeat (4) step(1, 1, 0, 16'h0);

        chk("wrap_size", log2.size(), 3);
        if (log2.size() == 3) begin
            chk("wrap_pc0", log2[0], 16'hFFFE);
            chk("wrap_pc1", log2[1], 16'hFFFF);
            chk("wrap_pc2", log2[2], 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
